// File: rtl/axistream_forwarder_pkg.sv
// Shared definitions for the forwarder: ceiling-log2 helper and FSM encoding.
package axistream_forwarder_pkg;

  // Ceiling log2, usable in parameter defaults.
  function automatic int CLOG2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLAIM = 3'd1,
    ST_LATCH = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } fwd_state_e;

endpackage

// File: rtl/axistream_forwarder_fifo.sv
// Output word buffer: synchronous FIFO with occupancy and a registered head word.
module forwarder_fifo
  import axistream_forwarder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [CLOG2(DEPTH):0]  occ
);
  localparam int PW = CLOG2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_rem;
  logic [WIDTH-1:0] head_q, head_d;

  // Next head: the incoming word if nothing else is left after a pop, else the next stored word.
  always_comb begin
    cnt_rem  = cnt_q - CW'(pop);
    cnt_d    = cnt_rem + CW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    head_d   = head_q;
    if (push && cnt_rem == '0) head_d = din;
    else if (cnt_rem != '0)    head_d = mem_q[rd_ptr_d];
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push);
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  assign dout  = head_q;
  assign empty = (cnt_q == '0);
  assign occ   = cnt_q;

endmodule

// File: rtl/axistream_forwarder.sv
// Reads one packet from packet memory and streams it out on AXI-Stream.
module axistream_forwarder
  import axistream_forwarder_pkg::*;
#(
  parameter int PACKET_MEM_BYTES  = 2048,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int SN_FWD_ADDR_WIDTH = CLOG2(PACKET_MEM_BYTES) - CLOG2(SN_FWD_DATA_WIDTH/8),
  parameter int PLEN_WIDTH        = 32,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy_for_fwd,
  output logic                           rdy_for_fwd_ack,
  output logic [SN_FWD_ADDR_WIDTH-1:0]   fwd_addr,
  output logic                           fwd_rd_en,
  input  logic [SN_FWD_DATA_WIDTH-1:0]   fwd_rd_data,
  input  logic                           fwd_rd_data_vld,
  input  logic [PLEN_WIDTH-1:0]          fwd_byte_len,
  output logic                           fwd_done,
  input  logic                           fwd_done_ack,
  output logic [SN_FWD_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [SN_FWD_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready
);
  localparam int BYTES = SN_FWD_DATA_WIDTH / 8;
  localparam int LOG_B = CLOG2(BYTES);
  localparam int LEN_W = CLOG2(PACKET_MEM_BYTES) + 1;
  localparam int NW_W  = LEN_W - LOG_B;
  localparam int CW    = CLOG2(FIFO_DEPTH) + 1;

  fwd_state_e state_q, state_d;
  logic             ack_q, ack_d;
  logic             rd_en, room, push, pop, empty, is_last;
  logic [LEN_W-1:0] len_q, len_c;
  logic [NW_W-1:0]  rd_cnt_q, beat_q, nwords;
  logic [CW-1:0]    out_q, occ;
  logic [LOG_B:0]   last_bytes;
  logic [BYTES-1:0] keep_last;
  logic [SN_FWD_DATA_WIDTH-1:0] head;

  // Length clamp, word count and last-beat byte count.
  assign len_c      = (fwd_byte_len > PLEN_WIDTH'(PACKET_MEM_BYTES)) ? LEN_W'(PACKET_MEM_BYTES)
                                                                     : LEN_W'(fwd_byte_len);
  assign nwords     = NW_W'((len_q + LEN_W'(BYTES - 1)) >> LOG_B);
  assign last_bytes = (len_q[LOG_B-1:0] == '0) ? (LOG_B+1)'(BYTES) : {1'b0, len_q[LOG_B-1:0]};

  // Read-ahead is limited so that every outstanding read is guaranteed a FIFO slot.
  assign room    = ({1'b0, occ} + {1'b0, out_q}) < (CW+1)'(FIFO_DEPTH);
  // Returning words are only accepted when a read is actually owed; stale returns after reset drop.
  assign push    = fwd_rd_data_vld && (out_q != '0);
  assign pop     = m_axis_tvalid && m_axis_tready;
  assign is_last = (beat_q == nwords - NW_W'(1));

  // Next-state logic, claim pulse and read strobe.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE:  if (rdy_for_fwd) begin
                  ack_d   = 1'b1;
                  state_d = ST_CLAIM;
                end
      ST_CLAIM: state_d = ST_LATCH;
      ST_LATCH: state_d = (len_c == '0) ? ST_DONE : ST_READ;
      ST_READ:  if (room) begin
                  rd_en = 1'b1;
                  if (rd_cnt_q == nwords - NW_W'(1)) state_d = ST_DRAIN;
                end
      ST_DRAIN: if (pop && is_last) state_d = ST_DONE;
      ST_DONE:  if (fwd_done_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered claim pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  // Packet length, read address, beat position and outstanding-read count.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      rd_cnt_q <= '0;
      beat_q   <= '0;
      out_q    <= '0;
    end else begin
      if (state_q == ST_LATCH) begin
        len_q    <= len_c;
        rd_cnt_q <= '0;
        beat_q   <= '0;
      end else begin
        rd_cnt_q <= rd_cnt_q + NW_W'(rd_en);
        beat_q   <= beat_q + NW_W'(pop);
      end
      out_q <= out_q + CW'(rd_en) - CW'(push);
    end
  end

  forwarder_fifo #(.WIDTH(SN_FWD_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fwd_rd_data),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .occ   (occ)
  );

  // Last-beat keep mask: LSB-contiguous bytes of the final word.
  always_comb begin
    keep_last = '0;
    for (int i = 0; i < BYTES; i++) keep_last[i] = (i < int'(last_bytes));
  end

  // AXIS presents the FIFO head; sideband is zeroed whenever no beat is offered.
  always_comb begin
    m_axis_tvalid = !empty;
    m_axis_tdata  = m_axis_tvalid ? head : '0;
    m_axis_tlast  = m_axis_tvalid && is_last;
    m_axis_tkeep  = '0;
    if (m_axis_tvalid) m_axis_tkeep = is_last ? keep_last : '1;
  end

  assign rdy_for_fwd_ack = ack_q;
  assign fwd_rd_en       = rd_en;
  assign fwd_addr        = SN_FWD_ADDR_WIDTH'(rd_cnt_q);
  assign fwd_done        = (state_q == ST_DONE);

endmodule

// File: doc/axistream_forwarder.md
AXISTREAM_FORWARDER -- requirements
Module: axistream_forwarder

Interface
REQ-001 SHALL have parameter PACKET_MEM_BYTES, default 2048, packet memory capacity in bytes.
REQ-002 SHALL have parameter SN_FWD_DATA_WIDTH, default 64, memory word and AXIS tdata width in bits.
REQ-003 SHALL have parameter SN_FWD_ADDR_WIDTH, default CLOG2(PACKET_MEM_BYTES)-CLOG2(SN_FWD_DATA_WIDTH/8), word address width.
REQ-004 SHALL have parameter PLEN_WIDTH, default 32, byte length width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of two, >=2).
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports rdy_for_fwd (input, 1, packet available) and rdy_for_fwd_ack (output, 1, claim pulse).
REQ-009 SHALL have ports fwd_addr (output, SN_FWD_ADDR_WIDTH, word address) and fwd_rd_en (output, 1, read strobe).
REQ-010 SHALL have ports fwd_rd_data (input, SN_FWD_DATA_WIDTH, read word) and fwd_rd_data_vld (input, 1, read word valid).
REQ-011 SHALL have port fwd_byte_len, input, PLEN_WIDTH, packet length in bytes.
REQ-012 SHALL have ports fwd_done (output, 1, packet finished) and fwd_done_ack (input, 1, finish acknowledged).
REQ-013 SHALL have ports m_axis_tdata (output, SN_FWD_DATA_WIDTH), m_axis_tkeep (output, SN_FWD_DATA_WIDTH/8), m_axis_tlast (output, 1), m_axis_tvalid (output, 1) and m_axis_tready (input, 1).

Function
REQ-014 SHALL implement FSM states IDLE, CLAIM, LATCH, READ, DRAIN, DONE.
REQ-015 IDLE: on rdy_for_fwd=1, SHALL assert rdy_for_fwd_ack for exactly one cycle and enter CLAIM.
REQ-016 CLAIM -> LATCH unconditionally; LATCH SHALL register fwd_byte_len, clamped to PACKET_MEM_BYTES.
REQ-017 SHALL compute word count as ceil(len/(SN_FWD_DATA_WIDTH/8)) and last-beat byte count as len mod 8, where 0 means 8.
REQ-018 When latched len=0, SHALL go LATCH -> DONE with no reads and no AXIS beats; otherwise LATCH -> READ.
REQ-019 READ: SHALL issue fwd_rd_en with fwd_addr = 0,1,2,... once per cycle while (FIFO occupancy + outstanding reads) < FIFO_DEPTH.
REQ-020 SHALL count outstanding reads (+1 on fwd_rd_en, -1 on fwd_rd_data_vld, both in the same cycle = no change) and tolerate arbitrary read latency.
REQ-021 After the final read has issued, SHALL go READ -> DRAIN.
REQ-022 Each fwd_rd_data_vld word SHALL be pushed into the FIFO; no overflow is possible by REQ-019.
REQ-023 AXIS SHALL present the FIFO head: tvalid=!empty; a beat transfers on tvalid&tready; tdata SHALL be held stable while tvalid&!tready.
REQ-024 Packet byte k of a word SHALL map to tdata[8k+7:8k]; tkeep SHALL be all-ones except on the last beat, where it is LSB-contiguous with the REQ-017 byte count.
REQ-025 tlast SHALL be 1 only on the final beat of the packet.
REQ-026 A simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-027 DRAIN -> DONE SHALL occur in the cycle after the tlast beat transfers.
REQ-028 DONE: SHALL hold fwd_done=1 until fwd_done_ack=1, then go to IDLE with fwd_done=0 in the next cycle.
REQ-029 rdy_for_fwd SHALL be ignored outside IDLE; back-to-back packets SHALL be supported with a minimum gap of 1 cycle in IDLE.

Reset
REQ-030 rst SHALL force IDLE, empty the FIFO, and clear the outstanding count, latched length and read address.
REQ-031 Outputs during and after reset SHALL be rdy_for_fwd_ack=0, fwd_rd_en=0, fwd_addr=0, fwd_done=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0.
REQ-032 Reset mid-packet SHALL abandon the packet without asserting fwd_done; read data returning after reset SHALL be discarded.

Structure
REQ-033 The CLOG2 macro and FSM state encodings SHALL live in a shared header package used by the fwd/sn side blocks.
REQ-034 The output buffer SHALL be a separate sub-module, forwarder_fifo (synchronous, occupancy output, registered head).

Verification
REQ-035 Single packet: len=20, tready=1, read latency 2 -> 3 beats; tkeep=FF,FF,0F; tlast on beat 3; fwd_done after beat 3; ack returns to IDLE.
REQ-036 Zero length: len=0 -> no fwd_rd_en, no tvalid, fwd_done asserted within 3 cycles of the claim.
REQ-037 Backpressure: len=64, tready toggled 1/0 randomly, latency 3 -> 8 beats, data in order, outstanding+occupancy never >4, tdata stable while stalled.
REQ-038 Exact multiple: len=16 -> 2 beats, both tkeep=FF, tlast on beat 2.
REQ-039 Overlength: len=4000 -> clamped to 2048, 256 beats, last tkeep=FF.
REQ-040 Reset mid-packet: rst asserted at beat 2 of a 10-beat packet -> all outputs 0 next cycle, no fwd_done, the next packet forwards correctly.
